// File: rtl/fetch_unit.sv
// Program-counter and fetch-control stage at the head of IF.
// Drives a 1-cycle-latency instruction memory and pairs each returned word with its PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic        if_fault_o,
    output logic [31:0] fetch_count_o
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pcF_q, pcF_d;
    logic        faultF_q, faultF_d;
    logic [31:0] fetchCount_q, fetchCount_d;
    logic [31:0] nextAddr;
    logic        accept;

    // Re-issuing pcF_q while held makes the memory re-present the same word.
    always_comb begin
        nextAddr = pcF_q + 32'd4;
        if (redirect_valid_i) begin
            nextAddr = {redirect_pc_i[31:2], 2'b00};
        end else if ((state_q != RUN) || stall_i) begin
            nextAddr = pcF_q;
        end
    end

    assign imem_addr_o   = rst ? RESET_PC : nextAddr;
    assign if_valid_o    = (state_q == RUN) && !redirect_valid_i;
    assign if_pc_o       = pcF_q;
    assign if_instr_o    = faultF_q ? NOP_INSTR : imem_rdata_i;
    assign if_fault_o    = faultF_q && if_valid_o;
    assign fetch_count_o = fetchCount_q;
    assign accept        = if_valid_o && !stall_i;

    always_comb begin
        pcF_d        = nextAddr;
        faultF_d     = faultF_q;
        fetchCount_d = fetchCount_q;
        state_d      = state_q;
        if (redirect_valid_i) begin
            faultF_d = (redirect_pc_i[1:0] != 2'b00);
        end
        if (accept) begin
            fetchCount_d = fetchCount_q + 32'd1;
        end
        // A redirect wins over halt and stall in every state.
        if (redirect_valid_i) begin
            state_d = RUN;
        end else begin
            case (state_q)
                BOOT:    state_d = RUN;
                RUN:     state_d = halt_i ? HALTED : RUN;
                HALTED:  state_d = HALTED;
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pcF_q        <= RESET_PC;
            faultF_q     <= 1'b0;
            fetchCount_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pcF_q        <= pcF_d;
            faultF_q     <= faultF_d;
            fetchCount_q <= fetchCount_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a slot-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        halt_i = 1'b0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_fault_o;
    logic [31:0] fetch_count_o;

    logic [31:0] mem [0:1023];

    int nChecks = 0;
    int nFails  = 0;

    // Model: 0 = booting, 1 = running, 2 = halted; mPc is the PC of the presented slot.
    int          mMode;
    logic [31:0] mPc;
    logic        mFault;
    logic [31:0] mCount;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .halt_i          (halt_i),
        .imem_addr_o     (imem_addr_o),
        .imem_rdata_i    (imem_rdata_i),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o),
        .if_instr_o      (if_instr_o),
        .if_fault_o      (if_fault_o),
        .fetch_count_o   (fetch_count_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata_i <= mem[imem_addr_o[11:2]];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        mMode  = 0;
        mPc    = RESET_PC;
        mFault = 1'b0;
        mCount = 32'd0;
    endtask

    // Drives one cycle of inputs, checks the combinational view, then advances the model.
    task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc,
                                 input logic hl);
        logic        expValid;
        logic [31:0] expAddr;
        @(negedge clk);
        stall_i          = st;
        redirect_valid_i = rv;
        redirect_pc_i    = rpc;
        halt_i           = hl;
        #1;
        expValid = (mMode == 1) && !rv;
        if (rv)                    expAddr = {rpc[31:2], 2'b00};
        else if (mMode != 1 || st) expAddr = mPc;
        else                       expAddr = mPc + 32'd4;
        checkOutput("valid", {31'd0, if_valid_o}, {31'd0, expValid});
        checkOutput("addr", imem_addr_o, expAddr);
        checkOutput("fault", {31'd0, if_fault_o}, {31'd0, mFault && expValid});
        checkOutput("count", fetch_count_o, mCount);
        if (expValid) begin
            checkOutput("pc", if_pc_o, mPc);
            checkOutput("instr", if_instr_o, mFault ? NOP_INSTR : mem[mPc[11:2]]);
        end
        if (expValid && !st) mCount = mCount + 32'd1;
        if (rv) mFault = (rpc[1:0] != 2'b00);
        mPc = expAddr;
        if (rv)                   mMode = 1;
        else if (mMode == 0)      mMode = 1;
        else if (mMode == 1 && hl) mMode = 2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic randomCycles(input int n);
        logic        st, rv, hl;
        logic [31:0] rpc;
        for (int i = 0; i < n; i++) begin
            st  = ($urandom_range(0, 99) < 25);
            rv  = ($urandom_range(0, 99) < 10);
            hl  = ($urandom_range(0, 99) < 5);
            rpc = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h1FFF));
            if ($urandom_range(0, 9) < 7) rpc[1:0] = 2'b00;
            applyStimulus(st, rv, rpc, hl);
        end
    endtask

    task automatic releaseReset();
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'd0;
        halt_i           = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        resetModel();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00a0_0113;
        resetModel();
        repeat (2) @(posedge clk);
        releaseReset();

        // Boot sequence: one dead cycle, then mem[0], mem[1].
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("boot_valid", {31'd0, if_valid_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("boot_pc0", if_pc_o, 32'h0);
        checkOutput("boot_instr0", if_instr_o, 32'h0050_0093);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("boot_pc1", if_pc_o, 32'h4);
        checkOutput("boot_instr1", if_instr_o, 32'h00a0_0113);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("boot_count", fetch_count_o, 32'd2);

        // Stall held at pc 0xC (model tracks stability each cycle).
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        idle(2);

        // Redirect, then redirect coinciding with stall.
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
        idle(2);
        applyStimulus(1'b1, 1'b1, 32'h80, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("redir_stall_pc", if_pc_o, 32'h80);

        // Misaligned target faults until the next aligned redirect.
        applyStimulus(1'b0, 1'b1, 32'h102, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("mis_pc", if_pc_o, 32'h100);
        checkOutput("mis_fault", {31'd0, if_fault_o}, 32'd1);
        checkOutput("mis_instr", if_instr_o, NOP_INSTR);
        idle(2);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
        idle(2);

        // Halt, idle while halted, resume with a redirect; also an aliased target.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        idle(4);
        applyStimulus(1'b1, 1'b1, 32'h24, 1'b1);
        idle(2);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        idle(3);

        randomCycles(1500);

        // Asynchronous reset mid-run: outputs clear before any clock edge.
        @(negedge clk);
        #2;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h40;
        rst              = 1'b1;
        #1;
        checkOutput("rst_valid", {31'd0, if_valid_o}, 32'd0);
        checkOutput("rst_fault", {31'd0, if_fault_o}, 32'd0);
        checkOutput("rst_count", fetch_count_o, 32'd0);
        checkOutput("rst_addr", imem_addr_o, RESET_PC);
        checkOutput("rst_pc", if_pc_o, RESET_PC);
        releaseReset();

        randomCycles(1500);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch-control stage at the head of IF, directly upstream of the synchronous-read instruction memory (4 KB, 1-cycle read latency).
- Drives the memory address every cycle and pairs each returned instruction word with its PC and a valid flag for the IF/ID register.
- Handles decode back-pressure (stall), control-flow redirects from EX, misaligned redirect targets, a halt request, and an accepted-fetch counter.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
- NOP_INSTR, 32'h0000_0013, word substituted on a faulted fetch (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  downstream cannot accept the current instruction.
- redirect_valid_i  in  1  taken branch/jump/trap; overrides everything.
- redirect_pc_i  in  32  redirect target byte address.
- halt_i  in  1  stop fetching (e.g. WFI/EBREAK) until the next redirect.
- imem_addr_o  out  32  byte address to instruction memory (combinational).
- imem_rdata_i  in  32  instruction word for the address driven the previous cycle.
- if_valid_o  out  1  if_instr_o/if_pc_o hold a real instruction.
- if_pc_o  out  32  PC of the word on if_instr_o.
- if_instr_o  out  32  fetched instruction.
- if_fault_o  out  1  instruction-address-misaligned fault for this slot.
- fetch_count_o  out  32  number of accepted instructions.

Behaviour:
- Registers: pc_f (address issued last cycle), fault_f, state {BOOT, RUN, HALTED}, fetch_count.
- Reset values: pc_f=RESET_PC, fault_f=0, state=BOOT, fetch_count=0. While rst is high, if_valid_o=0, if_fault_o=0, imem_addr_o=RESET_PC.
- imem_addr_o, evaluated in priority order:
  - redirect_valid_i: {redirect_pc_i[31:2],2'b00}.
  - state!=RUN, or stall_i: pc_f (re-issue the same address so the memory re-presents the held word).
  - otherwise: pc_f+4, wrapping mod 2^32.
- pc_f <= imem_addr_o every cycle. On redirect only, fault_f <= (redirect_pc_i[1:0]!=0); it is unchanged otherwise.
- Outputs:
  - if_valid_o = (state==RUN) & ~redirect_valid_i. A same-cycle redirect kills the word on the wire.
  - if_pc_o = pc_f.
  - if_instr_o = fault_f ? NOP_INSTR : imem_rdata_i.
  - if_fault_o = fault_f & if_valid_o.
- State transitions:
  - BOOT -> RUN after one cycle (the RESET_PC read is in flight). The first valid instruction appears 2 cycles after rst deasserts: 1 cycle BOOT, then data.
  - RUN -> HALTED when halt_i=1 and redirect_valid_i=0.
  - HALTED -> RUN only on redirect_valid_i; otherwise it stays HALTED with if_valid_o=0 and re-issues pc_f.
  - redirect_valid_i in any state -> RUN. Redirect beats halt_i and stall_i when they coincide.
- Steady-state throughput: 1 instruction per cycle.
- Stall: outputs stay stable, including if_instr_o, because the same address is re-read. Stall during BOOT/HALTED has no effect.
- fetch_count increments, wrapping, when if_valid_o & ~stall_i.
- Address range: only addr[11:2] reach the memory. PCs at or above 4 KB alias.
- A misaligned fault persists on every sequential fetch until the next aligned redirect; downstream traps on the first one.
- Reset mid-operation clears everything immediately; no partial outputs survive.

Test Plan:
- Reset release, mem[0]=0x00500093, mem[1]=0x00a00113 -> cycle 1: if_valid=0; cycle 2: if_pc=0, instr=0x00500093; cycle 3: if_pc=4, instr=0x00a00113; fetch_count=2 after cycle 3.
- stall_i high 3 cycles at if_pc=8 -> if_pc/if_instr constant, imem_addr=8 throughout, fetch_count frozen; release -> next cycle if_pc=0xC.
- redirect_valid_i with redirect_pc=0x40 while if_pc=0x10 -> same cycle if_valid=0; next cycle if_pc=0x40, instr=mem[16].
- Redirect and stall together, target 0x80 -> redirect wins: if_pc=0x80 next cycle, valid=1.
- Redirect to 0x102 -> next cycle if_pc=0x100, if_fault=1, if_instr=0x00000013; then redirect to 0x0 -> fault cleared.
- halt_i at if_pc=0x20 -> if_valid=0 indefinitely, imem_addr holds; redirect to 0x24 -> resumes with if_pc=0x24. Async rst pulse mid-run -> outputs reset instantly, fetch_count=0.
